// File: rtl/cnn_pkg.sv
// Shared encodings for the pmul feeder: FSM states, kernel geometry and weight indexing.
package cnn_pkg;

  localparam int unsigned KCOLS = 3;
  localparam int unsigned KSIZE = KCOLS * KCOLS;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StFill = 3'd1;
  localparam logic [2:0] StRun  = 3'd2;
  localparam logic [2:0] StB1   = 3'd3;
  localparam logic [2:0] StB2   = 3'd4;

  // Flat register-file index of kernel element (row, col).
  function automatic logic [3:0] kernel_idx(input logic [1:0] row, input logic [1:0] col);
    return 4'(row) * 4'(KCOLS) + 4'(col);
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of pixels: combinational indexed read, single registered write port.
module line_buffer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rd_data = mem_q[rd_addr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/pmul_feeder.sv
// Raster pixel stream to 3-lane pmul feeder: two line buffers form a 3-row column, and each
// pixel from row 2 onward is sent as three beats, one per kernel column.
module pmul_feeder
  import cnn_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8,
  localparam int unsigned CW   = $clog2(IMG_W),
  localparam int unsigned RW   = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             w_wr,
  input  logic [3:0]       w_addr,
  input  logic [WIDTH-1:0] w_data,
  input  logic [WIDTH-1:0] px_data,
  input  logic             px_vld,
  output logic             px_rdy,
  output logic             out_update,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_weight2,
  output logic [WIDTH-1:0] out_weight1,
  output logic [WIDTH-1:0] out_weight0,
  output logic [1:0]       out_kcol,
  output logic             busy,
  output logic             frame_done
);

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic             last_q, last_d;
  logic             busy_q;
  logic [WIDTH-1:0] w_q [KSIZE];

  logic             update_q, done_q;
  logic [1:0]       kcol_q;
  logic [WIDTH-1:0] data2_q, data1_q, data0_q;
  logic [WIDTH-1:0] weight2_q, weight1_q, weight0_q;

  logic             accept, run_accept, col_last, row_last;
  logic             beat_en, beat_done;
  logic [1:0]       beat_k;
  logic [WIDTH-1:0] top_px, mid_px;

  assign px_rdy     = (state_q == StFill) || (state_q == StRun);
  assign accept     = px_vld && px_rdy;
  assign run_accept = accept && (state_q == StRun);
  assign col_last   = (col_q == CW'(IMG_W - 1));
  assign row_last   = (row_q == RW'(IMG_H - 1));

  // lb_old holds row r-2, lb_new row r-1; each accept shifts the column down by one row.
  line_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (IMG_W)
  ) u_lb_old (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (col_q),
    .rd_data (top_px),
    .wr_en   (accept),
    .wr_addr (col_q),
    .wr_data (mid_px)
  );

  line_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (IMG_W)
  ) u_lb_new (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (col_q),
    .rd_data (mid_px),
    .wr_en   (accept),
    .wr_addr (col_q),
    .wr_data (px_data)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    last_d  = last_q;
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    case (state_q)
      StIdle: begin
        col_d  = '0;
        row_d  = '0;
        last_d = 1'b0;
        if (start) state_d = StFill;
      end
      StFill: begin
        if (accept && col_last && (row_q == RW'(1))) state_d = StRun;
      end
      StRun: begin
        if (accept) begin
          state_d = StB1;
          last_d  = col_last && row_last;
        end
      end
      StB1:    state_d = StB2;
      StB2:    state_d = last_q ? StIdle : StRun;
      default: state_d = StIdle;
    endcase
  end

  // Beat generation: k=0 is launched by the RUN accept, k=1/k=2 by B1/B2.
  always_comb begin
    beat_en   = 1'b0;
    beat_k    = 2'd0;
    beat_done = 1'b0;
    if (run_accept) begin
      beat_en = 1'b1;
      beat_k  = 2'd0;
    end else if (state_q == StB1) begin
      beat_en = 1'b1;
      beat_k  = 2'd1;
    end else if (state_q == StB2) begin
      beat_en   = 1'b1;
      beat_k    = 2'd2;
      beat_done = last_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      last_q  <= last_d;
      // busy stays up through the frame_done beat and drops the cycle after.
      if ((state_q == StIdle) && start) begin
        busy_q <= 1'b1;
      end else if (done_q) begin
        busy_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(KSIZE); i++) begin
        w_q[i] <= '0;
      end
    end else if ((state_q == StIdle) && w_wr && (w_addr < 4'(KSIZE))) begin
      w_q[w_addr] <= w_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      update_q  <= 1'b0;
      done_q    <= 1'b0;
      kcol_q    <= 2'd0;
      data2_q   <= '0;
      data1_q   <= '0;
      data0_q   <= '0;
      weight2_q <= '0;
      weight1_q <= '0;
      weight0_q <= '0;
    end else begin
      update_q <= beat_en;
      done_q   <= beat_done;
      if (run_accept) begin
        data2_q <= top_px;
        data1_q <= mid_px;
        data0_q <= px_data;
      end
      if (beat_en) begin
        kcol_q    <= beat_k;
        weight2_q <= w_q[kernel_idx(2'd0, beat_k)];
        weight1_q <= w_q[kernel_idx(2'd1, beat_k)];
        weight0_q <= w_q[kernel_idx(2'd2, beat_k)];
      end
    end
  end

  assign out_update  = update_q;
  assign out_data2   = data2_q;
  assign out_data1   = data1_q;
  assign out_data0   = data0_q;
  assign out_weight2 = weight2_q;
  assign out_weight1 = weight1_q;
  assign out_weight0 = weight0_q;
  assign out_kcol    = kcol_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_pmul_feeder.sv
// Scoreboard bench for pmul_feeder on a 3x3 image: stimulus pushes expected beats, a negedge
// monitor pops and compares them whenever out_update is seen.
module tb_pmul_feeder;

  typedef struct packed {
    logic [7:0] d2, d1, d0, w2, w1, w0;
    logic [1:0] k;
    logic       done;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       w_wr = 1'b0;
  logic [3:0] w_addr = '0;
  logic [7:0] w_data = '0;
  logic [7:0] px_data = '0;
  logic       px_vld = 1'b0;
  logic       px_rdy, out_update, busy, frame_done;
  logic [7:0] out_data2, out_data1, out_data0, out_weight2, out_weight1, out_weight0;
  logic [1:0] out_kcol;

  int    checks = 0;
  int    errors = 0;
  int    beats  = 0;
  int    cyc    = 0;
  beat_t exp_q[$];
  beat_t act, e;
  logic [7:0] img[9];
  logic [7:0] wt[9];

  pmul_feeder #(
    .WIDTH (8),
    .IMG_W (3),
    .IMG_H (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .w_wr        (w_wr),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .px_data     (px_data),
    .px_vld      (px_vld),
    .px_rdy      (px_rdy),
    .out_update  (out_update),
    .out_data2   (out_data2),
    .out_data1   (out_data1),
    .out_data0   (out_data0),
    .out_weight2 (out_weight2),
    .out_weight1 (out_weight1),
    .out_weight0 (out_weight0),
    .out_kcol    (out_kcol),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor: every beat must match the oldest expected beat.
  always @(negedge clk) begin
    if (rst) begin
      if (frame_done && !out_update) begin
        checks++;
        errors++;
        $display("FAIL frame_done_without_beat at cycle %0d", cyc);
      end
      if (out_update) begin
        beats++;
        checks++;
        act = '{out_data2, out_data1, out_data0, out_weight2, out_weight1, out_weight0,
                out_kcol, frame_done};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat got %h want none", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL beat got %h want %h", act, e);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input logic [3:0] a, input logic [7:0] d);
    w_wr = 1'b1;
    w_addr = a;
    w_data = d;
    tick();
    w_wr = 1'b0;
  endtask

  task automatic load_weights();
    for (int i = 0; i < 9; i++) begin
      wt[i] = 8'(i + 1);
      write_w(4'(i), wt[i]);
    end
  endtask

  task automatic push_beats(input int i);
    int r, c;
    beat_t b;
    r = i / 3;
    c = i % 3;
    for (int k = 0; k < 3; k++) begin
      b.d2 = img[(r - 2) * 3 + c];
      b.d1 = img[(r - 1) * 3 + c];
      b.d0 = img[r * 3 + c];
      b.w2 = wt[k];
      b.w1 = wt[3 + k];
      b.w0 = wt[6 + k];
      b.k = 2'(k);
      b.done = (i == 8) && (k == 2);
      exp_q.push_back(b);
    end
  endtask

  // Holds the pixel until accepted; returns the cycle number of the accepting edge.
  task automatic send(input logic [7:0] v, output int t);
    bit ok;
    ok = 1'b0;
    t = 0;
    px_data = v;
    px_vld = 1'b1;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (px_rdy) begin
        @(posedge clk);
        #1;
        t = cyc;
        ok = 1'b1;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout pixel %0h got no accept want accept", v);
    end
  endtask

  task automatic wait_frame_end(input string name);
    bit ended;
    ended = 1'b0;
    px_vld = 1'b0;
    for (int n = 0; n < 40 && !ended; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) ended = 1'b1;
    end
    chk({name, "_ended"}, 32'(ended), 32'd1);
    chk({name, "_rdy_idle"}, 32'(px_rdy), 32'd0);
    chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  // gapped: random idle cycles between pixels; inject: w_wr and start while the frame runs.
  task automatic run_frame(input string name, input bit gapped, input bit inject,
                           input bit wr_at_start);
    int t[9];
    int b0;
    b0 = beats;
    start = 1'b1;
    if (wr_at_start) begin
      w_wr = 1'b1;
      w_addr = 4'd8;
      w_data = 8'd20;
      wt[8] = 8'd20;
    end
    tick();
    start = 1'b0;
    w_wr = 1'b0;
    chk({name, "_busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < 9; i++) begin
      if (gapped) begin
        px_vld = 1'b0;
        repeat ($urandom_range(0, 5)) tick();
      end
      if (i >= 6) push_beats(i);
      send(img[i], t[i]);
      if (inject && i == 5) begin
        px_vld = 1'b0;
        write_w(4'd0, 8'hFF);
      end
      if (inject && i == 6) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    if (!gapped) begin
      for (int i = 1; i < 9; i++) begin
        chk($sformatf("%s_accept_gap%0d", name, i), 32'(t[i] - t[i-1]), (i >= 7) ? 32'd3 : 32'd1);
      end
    end
    wait_frame_end(name);
    chk({name, "_beat_count"}, 32'(beats - b0), 32'd9);
  endtask

  initial begin
    int t;
    for (int i = 0; i < 9; i++) begin
      img[i] = 8'(i + 1);
      wt[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rdy", 32'(px_rdy), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_update", 32'(out_update), 32'd0);
    chk("reset_data", {8'h0, out_data2, out_data1, out_data0}, 32'd0);
    chk("reset_weight", {8'h0, out_weight2, out_weight1, out_weight0}, 32'd0);
    chk("reset_done", 32'(frame_done), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    load_weights();
    write_w(4'd12, 8'hAA);
    run_frame("held", 1'b0, 1'b0, 1'b0);
    run_frame("gapped", 1'b1, 1'b1, 1'b0);
    run_frame("b2b_a", 1'b0, 1'b0, 1'b0);
    run_frame("b2b_b", 1'b0, 1'b0, 1'b0);

    // Abort a frame at row 2, col 1 once the row-2 col-0 beats have drained.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 6) push_beats(i);
      send(img[i], t);
    end
    px_vld = 1'b0;
    repeat (5) tick();
    chk("abort_pending", 32'(exp_q.size()), 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_rdy", 32'(px_rdy), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    px_vld = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("abort_update", 32'(out_update), 32'd0);
      chk("abort_rdy_after", 32'(px_rdy), 32'd0);
    end
    tick();
    px_vld = 1'b0;
    for (int i = 0; i < 9; i++) wt[i] = '0;
    load_weights();
    run_frame("restart", 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
